// File: rtl/adder_sum_accumulator.sv
// Accumulates a programmed number of unsigned adder sums into a wide register
// and presents the total with a sticky wrap flag over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; len latched into the remaining-sample counter
// ACCUM | accepting sums, one per cycle while in_valid is high
// DONE  | result held on out_acc/out_ovf until out_ready
module adder_sum_accumulator #(
    parameter int SUM_W = 9,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] remaining;
    logic             xfer;
    logic             last_xfer;
    logic [ACC_W:0]   sum_wide;

    assign xfer      = (state == ACCUM) && in_valid;
    assign last_xfer = xfer && (remaining == CNT_W'(1));

    // One extra bit captures the carry-out that feeds the sticky flag.
    assign sum_wide  = {1'b0, acc} + (ACC_W+1)'(in_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (last_xfer) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs depend on the state register only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
        end else if ((state == IDLE) && start) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= len;
        end else if (xfer) begin
            acc       <= sum_wide[ACC_W-1:0];
            ovf       <= ovf | sum_wide[ACC_W];
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign out_acc = acc;
    assign out_ovf = ovf;

endmodule
